// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine. A CPU write to DMA_REG latches a source page,
// halts the CPU through RDY, then copies 256 bytes from {page,00..FF} to
// OAM_PORT as alternating get (read) / put (write) cycles.
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004,
  parameter int          XFER_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  bus_din,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic        dma_we,
  output logic [7:0]  dma_dout
);

  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  buffer_q, buffer_d;
  logic        parity_q;

  logic        cpu_rdy_q, cpu_rdy_d;
  logic        dma_active_q, dma_active_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic        dma_rd_q, dma_rd_d;
  logic        dma_we_q, dma_we_d;
  logic [7:0]  dma_dout_q, dma_dout_d;

  // Next-state logic; outputs are decoded from the next state so the output
  // registers line up with the state register.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    count_d  = count_q;
    buffer_d = buffer_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_wr && (cpu_addr == DMA_REG)) begin
          page_d  = cpu_dout;
          count_d = 8'd0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // Halt only lands on a CPU read cycle. Parity 1 now means the next
        // cycle is a get, so the read can follow directly.
        if (cpu_rw) state_d = parity_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        buffer_d = bus_din;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (count_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_rdy_d    = (state_d == S_IDLE);
    dma_active_d = (state_d != S_IDLE);
    dma_rd_d     = (state_d == S_READ);
    dma_we_d     = (state_d == S_WRITE);
    dma_dout_d   = dma_dout_q;
    case (state_d)
      S_READ:  dma_addr_d = {page_d, count_d};
      S_WRITE: begin
        dma_addr_d = OAM_PORT;
        dma_dout_d = buffer_d;
      end
      default: dma_addr_d = 16'h0000;
    endcase
  end

  // State, datapath and output registers; reset aborts any transfer at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      page_q       <= 8'h00;
      count_q      <= 8'h00;
      buffer_q     <= 8'h00;
      parity_q     <= 1'b0;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
      dma_addr_q   <= 16'h0000;
      dma_rd_q     <= 1'b0;
      dma_we_q     <= 1'b0;
      dma_dout_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      count_q      <= count_d;
      buffer_q     <= buffer_d;
      parity_q     <= ~parity_q;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_active_q <= dma_active_d;
      dma_addr_q   <= dma_addr_d;
      dma_rd_q     <= dma_rd_d;
      dma_we_q     <= dma_we_d;
      dma_dout_q   <= dma_dout_d;
    end
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign dma_active = dma_active_q;
  assign dma_addr   = dma_addr_q;
  assign dma_rd     = dma_rd_q;
  assign dma_we     = dma_we_q;
  assign dma_dout   = dma_dout_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: reset, aligned/unaligned transfers, HALT
// extension, mid-transfer reset, non-triggering writes and page $FF.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [7:0]  bus_din;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        dma_we;
  logic [7:0]  dma_dout;

  int checks = 0;
  int failures = 0;
  int cyc;

  // Transfer statistics gathered by xfer()
  int          stall, nrd, nwr, gap, bad_rd, bad_wr, both, alt_err, act_err, exp_stall;
  bit          done;
  logic [15:0] first_rd, last_rd;

  oam_dma dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_rw(cpu_rw), .cpu_dout(cpu_dout), .bus_din(bus_din),
    .cpu_rdy(cpu_rdy), .dma_active(dma_active), .dma_addr(dma_addr),
    .dma_rd(dma_rd), .dma_we(dma_we), .dma_dout(dma_dout)
  );

  always #5 clk = ~clk;

  // Memory model: byte at address A is A[7:0] ^ $5A
  assign bus_din = dma_addr[7:0] ^ 8'h5A;

  // Cycles since reset release; its LSB is the get/put parity of the current cycle
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Trigger a transfer at the current negedge and watch it to completion.
  // zeros: HALT cycles with cpu_rw=0; stop_wr>0: return once that many puts seen.
  task automatic xfer(input logic [7:0] pg, input int zeros, input int stop_wr, input bit retrig);
    int p;
    stall = 0; nrd = 0; nwr = 0; gap = 0; bad_rd = 0; bad_wr = 0;
    both = 0; alt_err = 0; act_err = 0; done = 0;
    first_rd = 16'h0000; last_rd = 16'h0000;
    p = cyc % 2;
    // Last halt cycle parity; parity 0 there means an ALIGN cycle is needed
    exp_stall = 513 + zeros + (((p + 1 + zeros) % 2 == 0) ? 1 : 0);
    cpu_addr = 16'h4014; cpu_wr = 1'b1; cpu_dout = pg; cpu_rw = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      cpu_wr = 1'b0; cpu_addr = 16'h0000;
      if (retrig && i == 50) begin
        cpu_wr = 1'b1; cpu_addr = 16'h4014; cpu_dout = ~pg;
      end
      cpu_rw = (i < zeros) ? 1'b0 : 1'b1;
      if (cpu_rdy) begin
        done = 1;
        break;
      end
      stall++;
      if (dma_active !== 1'b1) act_err++;
      if (dma_rd && dma_we) both++;
      if (!dma_rd && !dma_we && nrd == 0) gap++;
      if (dma_rd) begin
        if (nrd == 0) first_rd = dma_addr;
        if (dma_addr !== {pg, nrd[7:0]}) bad_rd++;
        if (nrd != nwr) alt_err++;
        last_rd = dma_addr;
        nrd++;
      end
      if (dma_we) begin
        if (dma_addr !== 16'h2004 || dma_dout !== (nwr[7:0] ^ 8'h5A)) bad_wr++;
        if (nwr + 1 != nrd) alt_err++;
        nwr++;
      end
      if (stop_wr > 0 && nwr == stop_wr) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    cpu_wr = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0000;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL xfer_timeout page=%02h got stall=%0d exp completion within 2000 cycles", pg, stall);
    end
  endtask

  task automatic check_full(input string nm, input int exp_st, input int exp_gap);
    checks++; if (stall != exp_st) begin failures++; $display("FAIL %s stall got %0d exp %0d", nm, stall, exp_st); end
    checks++; if (gap != exp_gap) begin failures++; $display("FAIL %s pre_read_gap got %0d exp %0d", nm, gap, exp_gap); end
    checks++; if (nrd != 256) begin failures++; $display("FAIL %s reads got %0d exp 256", nm, nrd); end
    checks++; if (nwr != 256) begin failures++; $display("FAIL %s writes got %0d exp 256", nm, nwr); end
    checks++; if (bad_rd != 0) begin failures++; $display("FAIL %s bad_read_addr got %0d exp 0", nm, bad_rd); end
    checks++; if (bad_wr != 0) begin failures++; $display("FAIL %s bad_write got %0d exp 0", nm, bad_wr); end
    checks++; if (both + alt_err + act_err != 0) begin failures++; $display("FAIL %s both=%0d alt=%0d act=%0d exp 0", nm, both, alt_err, act_err); end
  endtask

  task automatic test_reset;
    int strobes, notrdy;
    reset = 1'b1; cpu_addr = 16'h0000; cpu_wr = 1'b0; cpu_rw = 1'b1; cpu_dout = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin failures++; $display("FAIL reset_ctrl got rdy=%b act=%b exp rdy=1 act=0", cpu_rdy, dma_active); end
    checks++; if (dma_rd !== 1'b0 || dma_we !== 1'b0) begin failures++; $display("FAIL reset_strobes got rd=%b we=%b exp 0 0", dma_rd, dma_we); end
    checks++; if (dma_addr !== 16'h0000 || dma_dout !== 8'h00) begin failures++; $display("FAIL reset_bus got addr=%h dout=%h exp 0000 00", dma_addr, dma_dout); end
    @(negedge clk);
    reset = 1'b0;
    strobes = 0; notrdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (dma_rd || dma_we || dma_active) strobes++;
      if (!cpu_rdy) notrdy++;
    end
    checks++; if (strobes + notrdy != 0) begin failures++; $display("FAIL idle_quiet got strobes=%0d notrdy=%0d exp 0 0", strobes, notrdy); end
  endtask

  task automatic test_aligned;
    if (cyc % 2 != 0) @(negedge clk);
    xfer(8'h02, 0, 0, 0);
    check_full("aligned", 513, 1);
    checks++; if (first_rd !== 16'h0200 || last_rd !== 16'h02FF) begin failures++; $display("FAIL aligned_range got %h..%h exp 0200..02FF", first_rd, last_rd); end
  endtask

  task automatic test_align_cycle;
    repeat (3) @(negedge clk);
    if (cyc % 2 != 1) @(negedge clk);
    xfer(8'h02, 0, 0, 0);
    check_full("align", 514, 2);
  endtask

  task automatic test_halt_extend;
    repeat (3) @(negedge clk);
    if (cyc % 2 != 0) @(negedge clk);
    xfer(8'h02, 2, 0, 1);
    check_full("halt_ext", 515, 3);
  endtask

  task automatic test_reset_abort;
    int wes;
    repeat (3) @(negedge clk);
    xfer(8'h02, 0, 100, 0);
    checks++; if (nwr != 100) begin failures++; $display("FAIL abort_reach got %0d exp 100", nwr); end
    reset = 1'b1;
    #1;
    checks++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0 || dma_we !== 1'b0) begin failures++; $display("FAIL abort_release got rdy=%b act=%b we=%b exp 1 0 0", cpu_rdy, dma_active, dma_we); end
    @(negedge clk);
    reset = 1'b0;
    wes = 0;
    repeat (20) begin
      @(negedge clk);
      if (dma_we || dma_rd) wes++;
    end
    checks++; if (wes != 0) begin failures++; $display("FAIL abort_no_more got %0d exp 0", wes); end
    xfer(8'h03, 0, 0, 0);
    check_full("restart", exp_stall, exp_stall - 512);
    checks++; if (first_rd !== 16'h0300) begin failures++; $display("FAIL restart_first got %h exp 0300", first_rd); end
  endtask

  task automatic test_no_trigger_and_ff;
    int act;
    repeat (2) @(negedge clk);
    act = 0;
    cpu_addr = 16'h4014; cpu_wr = 1'b0; cpu_dout = 8'h05;
    @(negedge clk);
    cpu_addr = 16'h0000;
    repeat (4) begin @(negedge clk); if (!cpu_rdy || dma_active) act++; end
    checks++; if (act != 0) begin failures++; $display("FAIL nowr_trigger got %0d busy cycles exp 0", act); end
    act = 0;
    cpu_addr = 16'h4015; cpu_wr = 1'b1; cpu_dout = 8'h05;
    @(negedge clk);
    cpu_addr = 16'h0000; cpu_wr = 1'b0;
    repeat (4) begin @(negedge clk); if (!cpu_rdy || dma_active) act++; end
    checks++; if (act != 0) begin failures++; $display("FAIL wrong_addr_trigger got %0d busy cycles exp 0", act); end
    xfer(8'hFF, 0, 0, 0);
    check_full("page_ff", exp_stall, exp_stall - 512);
    checks++; if (first_rd !== 16'hFF00 || last_rd !== 16'hFFFF) begin failures++; $display("FAIL page_ff_range got %h..%h exp FF00..FFFF", first_rd, last_rd); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_align_cycle();
    test_halt_extend();
    test_reset_abort();
    test_no_trigger_and_ff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine triggered by a CPU write to $4014, decoded on the CPU address bus alongside the address decoder.
- Halts the CPU through RDY and takes the CPU bus.
- Copies 256 bytes from page $XX00-$XXFF to the PPU OAM data port ($2004) as alternating get/put cycles.
- One clk edge equals one CPU cycle.

Parameters:
DMA_REG, 16'h4014, CPU address that triggers a transfer (written byte = source page)
OAM_PORT, 16'h2004, destination address driven on every put cycle
XFER_LEN, 256, bytes per transfer (counter width 8; fixed at 256)

Ports:
clk  input  1  CPU-cycle clock
reset  input  1  asynchronous, active-high reset
cpu_addr  input  16  CPU address bus
cpu_wr  input  1  CPU write strobe for the current cycle (1 = write)
cpu_rw  input  1  CPU cycle type (1 = read, 0 = write); halt takes effect only on a read
cpu_dout  input  8  CPU write data
bus_din  input  8  data bus returned to DMA on get cycles
cpu_rdy  output  1  RDY to CPU; 0 = CPU halted
dma_active  output  1  DMA owns the bus; external mux selects dma_* when 1
dma_addr  output  16  address driven by DMA
dma_rd  output  1  DMA read strobe (get cycle)
dma_we  output  1  DMA write strobe (put cycle)
dma_dout  output  8  data written to OAM_PORT

Behaviour:
- Reset (async, any time):
  - state=IDLE, cpu_rdy=1, dma_active=0, dma_rd=0, dma_we=0.
  - dma_addr=0, dma_dout=0, count=0, page=0, buffer=0, parity=0.
- Parity flop toggles every clk from reset release: parity 0 = get cycle, parity 1 = put cycle.
- Trigger: in IDLE, a clk edge with cpu_wr=1 and cpu_addr==DMA_REG latches page<=cpu_dout and count<=0, and moves to HALT.
  - cpu_wr=0, or any other address, is ignored.
  - Triggers are ignored in any state other than IDLE.
- All outputs are registered and take the new state's values the cycle after each transition.
- States:
  - IDLE: cpu_rdy=1, dma_active=0.
  - HALT: cpu_rdy=0, dma_active=1, dma_rd=0, dma_we=0. Each cycle with cpu_rw=0, stay in HALT (CPU not yet stalled). The first cycle with cpu_rw=1 is the halt cycle; exit at the end of it:
    - to READ if the next cycle is a get;
    - otherwise to ALIGN.
  - ALIGN: one dummy cycle, no strobes, then READ.
  - READ (get): dma_addr={page,count}, dma_rd=1. At the end of the cycle, buffer<=bus_din, then go to WRITE.
  - WRITE (put): dma_addr=OAM_PORT, dma_we=1, dma_dout=buffer. At the end of the cycle:
    - if count==255: go to IDLE;
    - else count<=count+1 and go to READ.
- cpu_rdy returns to 1 and dma_active to 0 on the cycle after the last WRITE.
- Source address never carries out of the page: page $FF reads $FF00-$FFFF only.
- Latency: trigger at cycle T with cpu_rw=1 at T+1 gives exactly 513 stalled cycles (1 halt + 512) with no align, or 514 with align. Each cpu_rw=0 cycle in HALT adds 1.
- READ and WRITE strictly alternate.
- dma_rd and dma_we are never high in the same cycle, and both are low outside READ/WRITE.
- Reset mid-transfer: abort at once. No further dma_we, and the bus is released. A later trigger restarts from count 0.

Test Plan:
1. Reset asserted mid-cycle, then released -> all outputs at reset values; cpu_rdy=1; idle 20 cycles with cpu_wr=0 -> no strobes.
2. Memory model $0200+i = i^8'h5A. Write $02 to $4014 so the halt cycle is put-parity (no align), cpu_rw=1 -> cpu_rdy low 513 cycles; 256 reads $0200..$02FF; 256 writes to $2004 with data i^$5A in order.
3. Same as 2, triggered one cycle later (align needed) -> cpu_rdy low 514 cycles; one strobe-free ALIGN cycle between halt and first read.
4. Hold cpu_rw=0 for 2 cycles after trigger -> HALT extends by 2, total 515 or 516; no strobes during HALT.
5. Assert reset after the 100th dma_we -> next cycle cpu_rdy=1, dma_active=0, no more writes. New trigger with page $03 -> reads start at $0300.
6. Writes with cpu_wr=0 at $4014, with cpu_wr=1 at $4015, and page $FF transfer -> first two: no trigger. Page $FF: last read at $FFFF, no access to $0000.
